// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared constants and types for the 8-way round-robin arbiter.
//   N_REQ           number of requesters
//   ID_W            width of a requester index
//   DEFAULT_TIMEOUT default grant timeout (only used with ARB_TIMEOUT_EN)
//   state_e         arbiter FSM state encoding
package rr_arbiter8_pkg;

  localparam int N_REQ           = 8;
  localparam int ID_W            = 3;
  localparam int DEFAULT_TIMEOUT = 15;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: requester/resource handshake bundle for rr_arbiter8.
//   req    requester -> arbiter, bit i high while requester i wants the resource
//   done   resource  -> arbiter, completion strobe for the current grant
//   gnt    arbiter   -> requesters, one-hot grant
//   gnt_id arbiter   -> shared 8:1 mux select
//   busy   arbiter   -> high while a grant is active
//   err    arbiter   -> one-cycle grant timeout pulse
// modport slave is the arbiter side, modport master the requester/resource side.
interface rr_arbiter8_if
  import rr_arbiter8_pkg::*;
  ();

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             err;

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output busy,
    output err
  );

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  err
  );

endinterface

// File: rtl/rr_arbiter8_pick8.sv
// rr_pick8: combinational round-robin pick.
//   req   [7:0] request vector
//   ptr   [2:0] last-granted index; scan starts at ptr+1 and wraps
//   win   [2:0] winning index (meaningful only when valid)
//   valid       any request present
// Rotates req so ptr+1 lands on bit 0, priority-encodes the lowest set bit,
// then adds the offset back to recover the absolute index.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  win,
  output logic             valid
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  idx;
  logic [ID_W-1:0]  first;

  always_comb begin
    rot   = '0;
    idx   = '0;
    first = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // ID_W-bit arithmetic gives the modulo-8 wrap for free
      idx    = ptr + ID_W'(i) + ID_W'(1);
      rot[i] = req[idx];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) first = ID_W'(i);
    end
    win   = ptr + first + ID_W'(1);
    valid = |req;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter sharing one resource among 8 requesters.
// Grants one requester at a time and holds it until done; on done the next
// requester is picked with the current grantee at lowest priority and granted
// on the same edge (no bubble).
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  rr_arbiter8_if.slave (req, done in; gnt, gnt_id, busy, err out)
// Parameters: TIMEOUT (2..255), RST_PTR (reset value of last-granted pointer).
// Optional macro ARB_TIMEOUT_EN: builds a grant timeout counter; on expiry the
// grant is released as if done were seen and err pulses for one cycle.
// Without it err is tied 0 and a grant holds indefinitely.
//
// state | meaning
// IDLE  | no grant; arbitrate on any req
// GRANT | gnt/gnt_id held until done (or timeout)
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int RST_PTR = 7
)(
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave bus
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rr_arbiter8: TIMEOUT out of range 2..255");
  end

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;

  logic [ID_W-1:0]  pick_ptr;
  logic [ID_W-1:0]  win;
  logic             valid;
  logic             release_g;
  logic             timeout;
  logic [N_REQ-1:0] one;

  // While granted, the pick must already see ptr = gnt_id so the releasing
  // edge can register the next winner directly.
  assign pick_ptr = (state_q == GRANT) ? gnt_id_q : ptr_q;
  assign one      = N_REQ'(1);

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .win   (win),
    .valid (valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  assign timeout = (state_q == GRANT) && !bus.done && (cnt_q == TO_LAST);
  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign release_g = (state_q == GRANT) && (bus.done || timeout);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          state_d  = GRANT;
          gnt_d    = one << win;
          gnt_id_d = win;
          busy_d   = 1'b1;
        end
      end
      GRANT: begin
        if (release_g) begin
          ptr_d = gnt_id_q;
          if (valid) begin
            gnt_d    = one << win;
            gnt_id_d = win;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= ID_W'(RST_PTR);
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    err_d = timeout;
    if (state_q == IDLE || release_g) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.TIMEOUT(4), .RST_PTR(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge; outputs are sampled and inputs changed 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic [7:0] g, input logic [2:0] id,
                         input logic b);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, ".id"}, 32'(bus.gnt_id), 32'(id));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
  endtask

  initial begin
    bus.req  = 8'h00;
    bus.done = 1'b0;
    rst      = 1'b1;

    // 1: reset held with a request present
    bus.req = 8'h01;
    step();
    chk_gnt("rst0", 8'h00, 3'd0, 1'b0);
    chk("rst0.err", 32'(bus.err), 32'd0);
    step();
    chk_gnt("rst1", 8'h00, 3'd0, 1'b0);
    rst = 1'b0;
    step();
    chk_gnt("first", 8'h01, 3'd0, 1'b1);

    // 2: all requesting, done every cycle -> 1..7,0 with no bubble
    bus.req  = 8'hFF;
    bus.done = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_gnt($sformatf("rr%0d", i), 8'h01 << (i % 8), 3'(i % 8), 1'b1);
    end
    bus.req  = 8'h00;
    bus.done = 1'b1;
    step();
    chk_gnt("to_idle", 8'h00, 3'd0, 1'b0);

    // 3: grant 3, grantee drops req, held until done
    bus.done = 1'b0;
    bus.req  = 8'h08;
    step();
    chk_gnt("g3", 8'h08, 3'd3, 1'b1);
    bus.req = 8'h10;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("hold%0d", i), 32'(bus.gnt), 32'h08);
    end
    bus.done = 1'b1;
    step();
    chk_gnt("g4", 8'h10, 3'd4, 1'b1);

    // 4: last grant 6 released, then 0 and 6 request -> 0 wins
    bus.req = 8'h40;
    step();
    chk_gnt("g6", 8'h40, 3'd6, 1'b1);
    bus.req = 8'h00;
    step();
    chk_gnt("idle6", 8'h00, 3'd6, 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'h41;
    step();
    chk_gnt("wrap0", 8'h01, 3'd0, 1'b1);

    // 5: reset with done while granted on 5 -> ptr back to 7
    bus.done = 1'b1;
    bus.req  = 8'h20;
    step();
    chk_gnt("g5", 8'h20, 3'd5, 1'b1);
    rst = 1'b1;
    step();
    chk_gnt("rst_mid", 8'h00, 3'd0, 1'b0);
    rst      = 1'b0;
    bus.done = 1'b0;
    bus.req  = 8'h81;
    step();
    chk_gnt("ptr_rst", 8'h01, 3'd0, 1'b1);
    chk("ptr_rst.err", 32'(bus.err), 32'd0);

    // 6: timeout behaviour
    bus.done = 1'b1;
    bus.req  = 8'h00;
    step();
    chk_gnt("idle0", 8'h00, 3'd0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'h0C;
    step();
    chk_gnt("g2", 8'h04, 3'd2, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("to_hold%0d", i), 32'(bus.gnt), 32'h04);
      chk($sformatf("to_err%0d", i), 32'(bus.err), 32'd0);
    end
    step();
    chk_gnt("to_g3", 8'h08, 3'd3, 1'b1);
    chk("to_pulse", 32'(bus.err), 32'd1);
    step();
    chk("to_pulse_end", 32'(bus.err), 32'd0);
    chk("to_g3_hold", 32'(bus.gnt), 32'h08);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      chk($sformatf("hold2_%0d", i), 32'(bus.gnt), 32'h04);
      chk($sformatf("noerr_%0d", i), 32'(bus.err), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
